// File: rtl/square_tone_player_if.sv
// Audio_Controller DAC FIFO write port: the player is the master, the FIFO is the slave.
interface square_tone_player_if;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/square_tone_player.sv
// Plays an 8-note C-major scale as square-wave tones, one sample per accepted FIFO write.
// The registered sample is always the one the next accepted write will consume.
module square_tone_player #(
  parameter logic [31:0] AMPLITUDE    = 32'h0800_0000,
  parameter int          NOTE_SAMPLES = 12000,
  parameter int          GAP_SAMPLES  = 2400,
  parameter bit          LOOP         = 1'b0
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stop,
  square_tone_player_if.master        aud,
  output logic                        busy,
  output logic [2:0]                  note_index
);

  localparam int DUR_W = ($clog2(NOTE_SAMPLES) > 14) ? $clog2(NOTE_SAMPLES) : 14;
  localparam int GAP_W = ($clog2(GAP_SAMPLES) > 1) ? $clog2(GAP_SAMPLES) : 1;
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_SAMPLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  // Last half_cnt value of each note's half-period (C4..C5 at 48 kHz, minus one).
  function automatic logic [6:0] half_last(input logic [2:0] note);
    case (note)
      3'd0:    half_last = 7'd91;
      3'd1:    half_last = 7'd81;
      3'd2:    half_last = 7'd72;
      3'd3:    half_last = 7'd68;
      3'd4:    half_last = 7'd60;
      3'd5:    half_last = 7'd54;
      3'd6:    half_last = 7'd48;
      default: half_last = 7'd45;
    endcase
  endfunction

  state_t           r_state, w_state;
  logic [2:0]       r_note, w_note;
  logic             r_phase, w_phase;
  logic [6:0]       r_half, w_half;
  logic [DUR_W-1:0] r_dur, w_dur;
  logic [GAP_W-1:0] r_gap, w_gap;
  logic [31:0]      r_sample, w_sample;
  logic             w_accept;

  assign w_accept                    = aud.audio_out_allowed & reset_n;
  assign aud.write_audio_out         = w_accept;
  assign aud.left_channel_audio_out  = r_sample;
  assign aud.right_channel_audio_out = r_sample;
  assign busy                        = (r_state != S_IDLE);
  assign note_index                  = r_note;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state = r_state;
    w_note  = r_note;
    w_phase = r_phase;
    w_half  = r_half;
    w_dur   = r_dur;
    w_gap   = r_gap;

    if (stop) begin
      w_state = S_IDLE;
      w_note  = 3'd0;
      w_phase = 1'b1;
      w_half  = '0;
      w_dur   = '0;
      w_gap   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state = S_PLAY;
            w_note  = 3'd0;
            w_phase = 1'b1;
            w_half  = '0;
            w_dur   = '0;
          end
        end
        S_PLAY: begin
          if (w_accept) begin
            if (r_half == half_last(r_note)) begin
              w_half  = '0;
              w_phase = ~r_phase;
            end else begin
              w_half = r_half + 7'd1;
            end
            if (r_dur == DUR_LAST) begin
              w_state = S_GAP;
              w_gap   = '0;
              w_dur   = '0;
            end else begin
              w_dur = r_dur + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (w_accept) begin
            if (r_gap == GAP_LAST) begin
              w_phase = 1'b1;
              w_half  = '0;
              w_dur   = '0;
              w_gap   = '0;
              if (r_note != 3'd7) begin
                w_state = S_PLAY;
                w_note  = r_note + 3'd1;
              end else begin
                w_state = LOOP ? S_PLAY : S_IDLE;
                w_note  = 3'd0;
              end
            end else begin
              w_gap = r_gap + 1'b1;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end

    // Sample depends only on the upcoming state, so it can only change at a state/phase step.
    w_sample = '0;
    if (w_state == S_PLAY) w_sample = w_phase ? AMPLITUDE : -AMPLITUDE;
  end

  // NOTE: only a few control/counter registers exist here and all of them are reset; there is no memory.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_note   <= 3'd0;
      r_phase  <= 1'b1;
      r_half   <= '0;
      r_dur    <= '0;
      r_gap    <= '0;
      r_sample <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      r_state  <= w_state;
      r_note   <= w_note;
      r_phase  <= w_phase;
      r_half   <= w_half;
      r_dur    <= w_dur;
      r_gap    <= w_gap;
      r_sample <= w_sample;
    end
  end

endmodule

// File: tb/tb_square_tone_player.sv
// Bench for square_tone_player: two instances (LOOP=0 and LOOP=1) share one stimulus and are
// checked every cycle against a write-index model of the scale, plus literal spot values.
module tb_square_tone_player;

  localparam int NS    = 200;
  localparam int GS    = 20;
  localparam int SLOT  = NS + GS;
  localparam int TOTAL = 8 * SLOT;
  localparam logic [31:0] AMP  = 32'h0800_0000;
  localparam logic [31:0] NAMP = 32'hF800_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic allowed = 1'b1;
  bit   rand_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int m_k[2];
  bit m_busy[2];

  always #10 clk = ~clk;

  square_tone_player_if aud0 ();
  square_tone_player_if aud1 ();
  assign aud0.audio_out_allowed = allowed;
  assign aud1.audio_out_allowed = allowed;

  logic        busy0, busy1;
  logic [2:0]  note0, note1;

  square_tone_player #(.NOTE_SAMPLES(NS), .GAP_SAMPLES(GS), .LOOP(1'b0)) u_dut (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .aud(aud0), .busy(busy0), .note_index(note0)
  );

  square_tone_player #(.NOTE_SAMPLES(NS), .GAP_SAMPLES(GS), .LOOP(1'b1)) u_loop (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .aud(aud1), .busy(busy1), .note_index(note1)
  );

  wire        d_write [2];
  wire [31:0] d_left  [2];
  wire [31:0] d_right [2];
  wire        d_busy  [2];
  wire [2:0]  d_note  [2];
  assign d_write[0] = aud0.write_audio_out;
  assign d_write[1] = aud1.write_audio_out;
  assign d_left[0]  = aud0.left_channel_audio_out;
  assign d_left[1]  = aud1.left_channel_audio_out;
  assign d_right[0] = aud0.right_channel_audio_out;
  assign d_right[1] = aud1.right_channel_audio_out;
  assign d_busy[0]  = busy0;
  assign d_busy[1]  = busy1;
  assign d_note[0]  = note0;
  assign d_note[1]  = note1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int half_period(input int note);
    case (note)
      0: return 92;
      1: return 82;
      2: return 73;
      3: return 69;
      4: return 61;
      5: return 55;
      6: return 49;
      default: return 46;
    endcase
  endfunction

  // Sample presented for the k-th accepted write after start.
  function automatic logic [31:0] exp_sample(input int k);
    int note, r;
    note = k / SLOT;
    r    = k % SLOT;
    if (r >= NS) return 32'h0;
    return (((r / half_period(note)) % 2) == 0) ? AMP : NAMP;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_busy[i] = 1'b0;
        m_k[i]    = 0;
      end
      check($sformatf("write[%0d]", i), {31'b0, d_write[i]}, {31'b0, allowed & reset_n});
      check($sformatf("left[%0d]", i), d_left[i], m_busy[i] ? exp_sample(m_k[i]) : 32'h0);
      check($sformatf("right[%0d]", i), d_right[i], m_busy[i] ? exp_sample(m_k[i]) : 32'h0);
      check($sformatf("busy[%0d]", i), {31'b0, d_busy[i]}, {31'b0, m_busy[i]});
      check($sformatf("note[%0d]", i), {29'b0, d_note[i]}, m_busy[i] ? 32'(m_k[i] / SLOT) : 32'h0);
      // Predict the state after the coming edge.
      if (!reset_n || stop) begin
        m_busy[i] = 1'b0;
        m_k[i]    = 0;
      end else if (!m_busy[i]) begin
        if (start) begin
          m_busy[i] = 1'b1;
          m_k[i]    = 0;
        end
      end else if (allowed) begin
        m_k[i]++;
        if (m_k[i] == TOTAL) begin
          m_k[i] = 0;
          if (i == 0) m_busy[i] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_en) allowed = 1'($urandom_range(0, 1));
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic at_k(input int target);
    int n;
    n = 0;
    while (!(m_busy[0] && m_k[0] == target) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: write %0d never reached", target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_busy[0] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: playback never ended");
    end
  endtask

  initial begin
    #5;
    check("reset_write", {31'b0, d_write[0]}, 32'h0);
    check("reset_left", d_left[0], 32'h0);
    check("reset_busy", {31'b0, d_busy[0]}, 32'h0);
    check("reset_note", {29'b0, d_note[0]}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_write", {31'b0, d_write[0]}, 32'h1);

    // Note 0 shape, gap, note 1, note 7, end of scale.
    pulse_start();
    at_k(0);    check("k0_left", d_left[0], AMP);
                check("k0_busy", {31'b0, d_busy[0]}, 32'h1);
    at_k(91);   check("k91_left", d_left[0], AMP);
    at_k(92);   check("k92_left", d_left[0], NAMP);
    at_k(183);  check("k183_left", d_left[0], NAMP);
    at_k(184);  check("k184_left", d_left[0], AMP);
    at_k(199);  check("k199_left", d_left[0], AMP);
    at_k(200);  check("k200_left", d_left[0], 32'h0);
    at_k(219);  check("k219_note", {29'b0, d_note[0]}, 32'h0);
    at_k(220);  check("k220_note", {29'b0, d_note[0]}, 32'h1);
                check("k220_left", d_left[0], AMP);
    at_k(1540); check("k1540_note", {29'b0, d_note[0]}, 32'h7);
    at_k(1585); check("k1585_left", d_left[0], AMP);
    at_k(1586); check("k1586_left", d_left[0], NAMP);
    at_k(1632); check("k1632_left", d_left[0], AMP);
    wait_idle(2000);
    check("end_busy", {31'b0, d_busy[0]}, 32'h0);
    check("end_note", {29'b0, d_note[0]}, 32'h0);
    check("end_left", d_left[0], 32'h0);
    check("loop_busy", {31'b0, d_busy[1]}, 32'h1);
    check("loop_note", {29'b0, d_note[1]}, 32'h0);
    check("loop_left", d_left[1], AMP);
    pulse_stop();

    // Asynchronous reset in the middle of a note.
    pulse_start();
    at_k(50);
    reset_n = 1'b0;
    #1;
    check("async_left0", d_left[0], 32'h0);
    check("async_busy0", {31'b0, d_busy[0]}, 32'h0);
    check("async_write0", {31'b0, d_write[0]}, 32'h0);
    check("async_left1", d_left[1], 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Full scale with a randomly stalling FIFO.
    rand_en = 1'b1;
    pulse_start();
    wait_idle(9000);
    rand_en = 1'b0;
    allowed = 1'b1;
    check("rand_end_note", {29'b0, d_note[0]}, 32'h0);
    pulse_stop();

    // start+stop together from IDLE stays idle.
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    check("startstop_busy", {31'b0, d_busy[0]}, 32'h0);

    // start while busy is ignored; stop mid-note 3.
    pulse_start();
    at_k(230);
    pulse_start();
    check("restart_note", {29'b0, d_note[0]}, 32'h1);
    check("restart_busy", {31'b0, d_busy[0]}, 32'h1);
    at_k(3 * SLOT + 149);
    pulse_stop();
    check("stop_left", d_left[0], 32'h0);
    check("stop_busy", {31'b0, d_busy[0]}, 32'h0);
    check("stop_note", {29'b0, d_note[0]}, 32'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
